ram_pair_reader: RTL and testbench

- Read-side master for the 16-entry dual-port RAM. It drives addr_a/addr_b with a consecutive address pair and captures data_a/data_b.
- It emits the words as a 16-bit valid/ready stream toward the downstream datapath.
- It is the reader counterpart of the RAM's write port (in_data/write_en): it walks a block of count words starting at base_addr.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_pair_reader.sv | 180 ++++++++++++++++++
 tb/tb_ram_pair_reader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM pair reader.
// Holds the reader FSM encoding and the default RAM geometry.
package ram_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        EMIT_A  = 3'd4,
        EMIT_B  = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/ram_pair_reader.sv
// Read-side master for the dual-port RAM: walks `count` words from
// `base_addr` two at a time (ports A/B) and streams them out.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start/base_addr/count transfer request, sampled in IDLE
//   busy, done            transfer in flight / one-cycle completion pulse
//   addr_a/addr_b         RAM read addresses (ptr, ptr+1 mod depth)
//   data_a/data_b         RAM read data
//   out_data/out_valid/out_ready/out_last  16-bit valid/ready stream
module ram_pair_reader
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   REM_TWO = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_TWO = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] PTR_THR = ADDR_W'(3);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   buf_b_q, buf_b_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hs;

    assign hs = out_valid_q && out_ready;

    // Outputs are all registered: each _d is the value for the
    // state being entered, so they line up with state_q.
    // out_data_q doubles as buf_a: data_a is loaded straight into
    // it on the CAPTURE edge and held until the EMIT_A handshake.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        buf_b_d     = buf_b_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        ptr_d    = base_addr;
                        rem_d    = count;
                        addr_a_d = base_addr;
                        addr_b_d = base_addr + PTR_ONE;
                        busy_d   = 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = (RD_LAT == 0) ? CAPTURE : WAIT;
            end
            WAIT: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                buf_b_d     = data_b;
                out_data_d  = data_a;
                out_valid_d = 1'b1;
                out_last_d  = (rem_q == REM_ONE);
                state_d     = EMIT_A;
            end
            EMIT_A: begin
                if (hs) begin
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        // Odd tail: buf_b is dropped.
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end else begin
                        out_data_d = buf_b_q;
                        out_last_d = (rem_q == REM_TWO);
                        state_d    = EMIT_B;
                    end
                end
            end
            EMIT_B: begin
                if (hs) begin
                    rem_d       = rem_q - REM_ONE;
                    ptr_d       = ptr_q + PTR_TWO;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (rem_q == REM_ONE) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_a_d = ptr_q + PTR_TWO;
                        addr_b_d = ptr_q + PTR_THR;
                        state_d  = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            buf_b_q     <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            buf_b_q     <= buf_b_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_ram_pair_reader.sv
// Scoreboard bench for ram_pair_reader with a registered-read RAM model.
// Expected words and address pairs are queued at start, checked on handshake.
module tb_ram_pair_reader;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          busy, done;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;

    ram_pair_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];

    always @(posedge clk) begin
        data_a <= mem[addr_a];
        data_b <= mem[addr_b];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    logic [16:0] exp_q [$];
    logic [7:0]  addr_q [$];

    int          done_cnt = 0;
    int          hs_cnt = 0;
    int          wcnt = 0;
    int          stall_cnt = 0;
    bit          busy_seen = 0;
    bit          valid_seen = 0;
    bit          mon_en = 1;
    bit          pend_done = 0;
    bit          stalled = 0;
    logic [DW-1:0] held_data;
    logic        held_last;
    logic [16:0] e;
    logic [7:0]  ap;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_seen = 1;
        if (out_valid) valid_seen = 1;
        if (mon_en) begin
            if (pend_done) begin
                chk("done_after_last", {31'b0, done}, 1);
                pend_done = 0;
            end
            if (stalled) begin
                chk("hold_valid", {31'b0, out_valid}, 1);
                chk("hold_data", {16'b0, out_data}, {16'b0, held_data});
                chk("hold_last", {31'b0, out_last}, {31'b0, held_last});
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (stalled) stall_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                chk("word_expected", {31'b0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", {16'b0, out_data}, {16'b0, e[15:0]});
                    chk("out_last", {31'b0, out_last}, {31'b0, e[16]});
                    if (e[16]) pend_done = 1;
                end
                if (wcnt % 2 == 0) begin
                    chk("pair_expected", {31'b0, addr_q.size() > 0}, 1);
                    if (addr_q.size() > 0) begin
                        ap = addr_q.pop_front();
                        chk("addr_pair", {24'b0, addr_a, addr_b}, {24'b0, ap});
                    end
                end
                wcnt++;
            end
        end
    end

    task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] c);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(c); i++) begin
            a = b + AW'(i);
            exp_q.push_back({(i == int'(c) - 1), mem[a]});
        end
        for (int p = 0; p < (int'(c) + 1) / 2; p++) begin
            a = b + AW'(2 * p);
            addr_q.push_back({a, a + 4'd1});
        end
        wcnt      = 0;
        start     = 1'b1;
        base_addr = b;
        count     = c;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < max_cyc) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_seen", {31'b0, done_cnt > d0}, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("done_width", done_cnt - d0, 1);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    int h0;
    int d0;
    int k;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_last", {31'b0, out_last}, 0);
        chk("rst_addr", {24'b0, addr_a, addr_b}, 0);
        chk("rst_data", {16'b0, out_data}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic aligned block.
        h0 = hs_cnt;
        start_xfer(4'd2, 5'd4);
        chk("busy_after_start", {31'b0, busy}, 1);
        wait_done(60);
        chk("hs_basic", hs_cnt - h0, 4);

        // Odd count: only buf_a of the last pair.
        h0 = hs_cnt;
        start_xfer(4'd0, 5'd3);
        wait_done(60);
        chk("hs_odd", hs_cnt - h0, 3);

        // Address wrap.
        start_xfer(4'd15, 5'd4);
        wait_done(60);

        // Full depth.
        h0 = hs_cnt;
        start_xfer(4'd5, 5'd16);
        wait_done(200);
        chk("hs_full", hs_cnt - h0, 16);

        // Backpressure in EMIT_A.
        out_ready = 1'b0;
        stall_cnt = 0;
        start_xfer(4'd0, 5'd2);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp_valid", {31'b0, out_valid}, 1);
        chk("bp_data", {16'b0, out_data}, 32'h1000);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(60);
        chk("bp_stalls", {31'b0, stall_cnt >= 5}, 1);

        // count = 0.
        busy_seen  = 0;
        valid_seen = 0;
        start_xfer(4'd3, 5'd0);
        wait_done(10);
        chk("zero_busy", {31'b0, busy_seen}, 0);
        chk("zero_valid", {31'b0, valid_seen}, 0);

        // start while busy is ignored.
        h0 = hs_cnt;
        start_xfer(4'd2, 5'd4);
        repeat (3) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 4'd9;
        count     = 5'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(60);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_hs", hs_cnt - h0, 4);
        chk("mid_idle", {30'b0, out_valid, busy}, 0);

        // Reset during EMIT_B.
        h0 = hs_cnt;
        start_xfer(4'd0, 5'd4);
        k = 0;
        while (hs_cnt == h0 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rst_mid_reached", {31'b0, hs_cnt > h0}, 1);
        mon_en    = 0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        d0        = done_cnt;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", {31'b0, out_valid}, 0);
        chk("rst_mid_busy", {31'b0, busy}, 0);
        rst_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        stalled   = 0;
        pend_done = 0;
        out_ready = 1'b1;
        mon_en    = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid_no_done", done_cnt - d0, 0);
        h0 = hs_cnt;
        start_xfer(4'd8, 5'd2);
        wait_done(60);
        chk("after_rst_hs", hs_cnt - h0, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
